// File: rtl/nn_pkg.sv
// Constants shared by the shift register, the control FSM and the output collector.
package nn_pkg;

   localparam int unsigned NN_DATA_W      = 8;
   localparam int unsigned NN_NUM_NEURONS = 4;

   localparam logic [1:0] SEL_SHIFT = 2'b00;
   localparam logic [1:0] SEL_HOLD  = 2'b01;
   localparam logic [1:0] SEL_LOAD  = 2'b10;

   typedef enum logic {
      ST_IDLE,
      ST_COLLECT
   } collect_state_e;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO: head word is shown combinationally, pop on valid&&ready,
// push accepted when not full or when a pop frees a slot on the same edge.
module result_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   output logic             o_push_ok,
   output logic             o_full,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   assign o_valid   = (r_count != '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign w_pop     = o_valid && i_ready;
   assign o_push_ok = i_push && (!o_full || w_pop);
   assign o_data    = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (o_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({o_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/network_output_collector.sv
// Collects result bytes shifted out of the input shift register, packs one word per
// inference (first byte out lands in the top lane) and queues it for a valid/ready sink.
module network_output_collector
   import nn_pkg::*;
#(
   parameter int unsigned DATA_W      = NN_DATA_W,
   parameter int unsigned NUM_NEURONS = NN_NUM_NEURONS,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [1:0]                    selector,
   input  logic [DATA_W-1:0]             network_outputs,
   input  logic                          results_loaded,
   output logic [NUM_NEURONS*DATA_W-1:0] result_data,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic                          busy,
   output logic                          overflow,
   output logic                          protocol_err
);

   localparam int unsigned WORD_W = NUM_NEURONS * DATA_W;
   localparam int unsigned CNT_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

   collect_state_e    r_state;
   collect_state_e    w_state_nxt;
   logic              r_shift_d;
   logic [CNT_W-1:0]  r_cnt;
   logic [WORD_W-1:0] r_data;
   logic              r_overflow;
   logic              r_protocol_err;

   logic              w_armed;
   logic              w_capture;
   logic              w_complete;
   logic [CNT_W-1:0]  w_lane;
   logic [WORD_W-1:0] w_word;
   logic              w_push_ok;
   logic              w_fifo_full;

   assign w_armed    = (r_state == ST_COLLECT);
   assign w_capture  = r_shift_d && w_armed;
   assign w_complete = w_capture && (r_cnt == CNT_W'(NUM_NEURONS - 1));
   assign w_lane     = CNT_W'(NUM_NEURONS - 1) - r_cnt;

   always_comb begin
      w_word = r_data;
      w_word[w_lane*DATA_W +: DATA_W] = network_outputs;
   end

   // A completing capture and a fresh results_loaded on the same edge both take
   // effect: the word is pushed, then the collector is re-armed.
   always_comb begin
      w_state_nxt = r_state;
      if (results_loaded) begin
         w_state_nxt = ST_COLLECT;
      end else if (w_complete) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_shift_d      <= 1'b0;
         r_cnt          <= '0;
         r_data         <= '0;
         r_overflow     <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_shift_d <= (selector == SEL_SHIFT);
         if (results_loaded) begin
            r_cnt  <= '0;
            r_data <= '0;
            if (w_armed && (r_cnt != '0) && !w_complete) begin
               r_protocol_err <= 1'b1;
            end
         end else if (w_capture) begin
            r_cnt  <= w_complete ? '0 : r_cnt + 1'b1;
            r_data <= w_complete ? '0 : w_word;
         end
         if (w_complete && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   result_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .i_push      (w_complete),
      .i_push_data (w_word),
      .o_push_ok   (w_push_ok),
      .o_full      (w_fifo_full),
      .o_valid     (result_valid),
      .o_data      (result_data),
      .i_ready     (result_ready)
   );

   assign busy         = w_armed;
   assign overflow     = r_overflow;
   assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_network_output_collector.sv
// Directed bench: stimulus pushes expected words to a queue, a negedge monitor pops
// and compares every accepted output word.
module tb_network_output_collector;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  selector;
   logic [7:0]  network_outputs;
   logic        results_loaded;
   logic [31:0] result_data;
   logic        result_valid;
   logic        result_ready;
   logic        busy;
   logic        overflow;
   logic        protocol_err;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_q [$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;

   always #5 clk = ~clk;

   network_output_collector #(
      .DATA_W      (8),
      .NUM_NEURONS (4),
      .FIFO_DEPTH  (2)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .selector        (selector),
      .network_outputs (network_outputs),
      .results_loaded  (results_loaded),
      .result_data     (result_data),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .busy            (busy),
      .overflow        (overflow),
      .protocol_err    (protocol_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard pops and stall-stability checks
   always @(negedge clk) begin
      if (rstn) begin
         if (prev_stall && result_valid) begin
            check("stall_stable", result_data, prev_data);
         end
         if (result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_word: got 0x%08h expected none", result_data);
            end else begin
               check("scoreboard", result_data, exp_q.pop_front());
            end
         end
         prev_stall = result_valid && !result_ready;
         prev_data  = result_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pulse();
      selector       = 2'b10;
      results_loaded = 1'b1;
      tick();
      results_loaded = 1'b0;
      selector       = 2'b01;
   endtask

   // One shift: selector=00 for a cycle, byte presented on the following cycle.
   task automatic shift_byte(input logic [7:0] b, input logic ready_at_capture);
      selector = 2'b00;
      tick();
      selector        = 2'b01;
      network_outputs = b;
      if (ready_at_capture) result_ready = 1'b1;
      tick();
      if (ready_at_capture) result_ready = 1'b0;
   endtask

   task automatic shift_word(input logic [31:0] w, input logic ready_last);
      logic [31:0] t;
      t = w;
      for (int k = 0; k < 4; k++) begin
         shift_byte(t[31-8*k -: 8], (k == 3) ? ready_last : 1'b0);
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      result_ready = 1'b1;
      while (result_valid && guard < 10) begin
         tick();
         guard++;
      end
      result_ready = 1'b0;
      if (guard >= 10) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got valid=1 expected valid=0");
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid"}, {31'd0, result_valid}, 32'd0);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
      check({name, "_ovf"}, {31'd0, overflow}, 32'd0);
      check({name, "_perr"}, {31'd0, protocol_err}, 32'd0);
   endtask

   initial begin
      rstn            = 1'b0;
      selector        = 2'b01;
      network_outputs = '0;
      results_loaded  = 1'b0;
      result_ready    = 1'b0;
      tick();
      tick();
      check_idle("reset");
      check("reset_data", result_data, 32'h0);
      rstn = 1'b1;

      // Unarmed shifts are ignored
      for (int k = 0; k < 4; k++) shift_byte(8'hAA, 1'b0);
      check_idle("unarmed");

      // Basic word
      load_pulse();
      check("basic_busy", {31'd0, busy}, 32'd1);
      exp_q.push_back(32'h33221100);
      shift_word(32'h33221100, 1'b0);
      check("basic_valid", {31'd0, result_valid}, 32'd1);
      check("basic_data", result_data, 32'h33221100);
      check("basic_busy_done", {31'd0, busy}, 32'd0);
      drain();

      // Pause mid-collection
      load_pulse();
      exp_q.push_back(32'h04030201);
      shift_byte(8'h04, 1'b0);
      shift_byte(8'h03, 1'b0);
      for (int k = 0; k < 5; k++) begin
         selector = 2'b01;
         tick();
         check("pause_busy", {31'd0, busy}, 32'd1);
      end
      check("pause_valid", {31'd0, result_valid}, 32'd0);
      shift_byte(8'h02, 1'b0);
      shift_byte(8'h01, 1'b0);
      check("pause_busy_done", {31'd0, busy}, 32'd0);
      drain();

      // Backpressure and overflow
      exp_q.push_back(32'h01010101);
      exp_q.push_back(32'h02020202);
      load_pulse(); shift_word(32'h01010101, 1'b0);
      load_pulse(); shift_word(32'h02020202, 1'b0);
      check("full_ovf_before", {31'd0, overflow}, 32'd0);
      load_pulse(); shift_word(32'h03030303, 1'b0);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_head", result_data, 32'h01010101);
      for (int k = 0; k < 3; k++) tick();
      drain();
      check("ovf_sticky", {31'd0, overflow}, 32'd1);

      do_reset();
      check_idle("reset2");

      // Full FIFO with pop coinciding with completion
      exp_q.push_back(32'h0A0B0C0D);
      exp_q.push_back(32'h1A1B1C1D);
      exp_q.push_back(32'h2A2B2C2D);
      load_pulse(); shift_word(32'h0A0B0C0D, 1'b0);
      load_pulse(); shift_word(32'h1A1B1C1D, 1'b0);
      load_pulse(); shift_word(32'h2A2B2C2D, 1'b1);
      check("simul_ovf", {31'd0, overflow}, 32'd0);
      check("simul_head", result_data, 32'h1A1B1C1D);
      drain();

      // Protocol error then clean word
      load_pulse();
      shift_byte(8'hEE, 1'b0);
      shift_byte(8'hDD, 1'b0);
      load_pulse();
      check("perr_flag", {31'd0, protocol_err}, 32'd1);
      exp_q.push_back(32'h10203040);
      shift_word(32'h10203040, 1'b0);
      check("perr_clean", result_data, 32'h10203040);
      drain();

      // Reset mid-collection
      load_pulse();
      shift_byte(8'h55, 1'b0);
      shift_byte(8'h66, 1'b0);
      do_reset();
      check_idle("midreset");
      check("midreset_data", result_data, 32'h0);
      for (int k = 0; k < 4; k++) shift_byte(8'h77, 1'b0);
      check_idle("post_reset_shifts");

      check("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
